// File: rtl/multicycle_controller_if.sv
// Control bundle between the RV32I multicycle controller (master) and its datapath (slave).
// The instruction fields and the zero flag flow in; enables, mux selects, ALU code and debug state flow out.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;

   logic       PCWrite;
   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       AdrSrc;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   modport master (
      input  op, funct3, funct7b5, zero,
      output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
      output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
      input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-FSM controller for an RV32I multicycle datapath (lw, sw, R/I ALU ops, jal, beq).
// Optional macro CTRL_BNE_EN adds bne (funct3=001, branch when zero=0) in the BEQ state.
module multicycle_controller (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_controller_if.master bus
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic       pcupdate;
   logic       branch;
   logic       irwrite_s;
   logic       memwrite_s;
   logic       regwrite_s;
   logic       adrsrc_s;
   logic [1:0] resultsrc_s;
   logic [1:0] alusrca_s;
   logic [1:0] alusrcb_s;
   logic [1:0] aluop;
   logic       branch_cond;

   function automatic logic [1:0] imm_decode(input logic [6:0] opcode);
      case (opcode)
         OP_LOAD,
         OP_ITYPE:  imm_decode = 2'b00;
         OP_STORE:  imm_decode = 2'b01;
         OP_BRANCH: imm_decode = 2'b10;
         OP_JAL:    imm_decode = 2'b11;
         default:   imm_decode = 2'b00;
      endcase
   endfunction

   // Only R-type (op[5]=1) with funct7b5 turns funct3=000 into sub; addi never subtracts.
   function automatic logic [2:0] alu_decode(input logic [1:0] op_class,
                                             input logic [2:0] f3,
                                             input logic       op5,
                                             input logic       f7b5);
      case (op_class)
         2'b00: alu_decode = 3'b000;
         2'b01: alu_decode = 3'b001;
         2'b10: begin
            case (f3)
               3'b000:  alu_decode = (op5 & f7b5) ? 3'b001 : 3'b000;
               3'b010:  alu_decode = 3'b101;
               3'b110:  alu_decode = 3'b011;
               3'b111:  alu_decode = 3'b010;
               default: alu_decode = 3'b000;
            endcase
         end
         default: alu_decode = 3'b000;
      endcase
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3, input logic z);
      case (f3)
         3'b000:  branch_taken = z;
`ifdef CTRL_BNE_EN
         3'b001:  branch_taken = ~z;
`endif
         default: branch_taken = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Unused encodings 11-15 fall into the default and recover through Fetch.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LOAD,
               OP_STORE:  state_d = S_MEMADR;
               OP_RTYPE:  state_d = S_EXECR;
               OP_ITYPE:  state_d = S_EXECI;
               OP_JAL:    state_d = S_JAL;
               OP_BRANCH: state_d = S_BEQ;
               default:   state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI,
         S_JAL:      state_d = S_ALUWB;
         S_MEMWB,
         S_MEMWRITE,
         S_ALUWB,
         S_BEQ:      state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pcupdate    = 1'b0;
      branch      = 1'b0;
      irwrite_s   = 1'b0;
      memwrite_s  = 1'b0;
      regwrite_s  = 1'b0;
      adrsrc_s    = 1'b0;
      resultsrc_s = 2'b00;
      alusrca_s   = 2'b00;
      alusrcb_s   = 2'b00;
      aluop       = 2'b00;
      case (state_q)
         S_FETCH: begin
            alusrcb_s   = 2'b10;
            resultsrc_s = 2'b10;
            irwrite_s   = 1'b1;
            pcupdate    = 1'b1;
         end
         S_DECODE: begin
            alusrca_s = 2'b01;
            alusrcb_s = 2'b01;
         end
         S_MEMADR: begin
            alusrca_s = 2'b10;
            alusrcb_s = 2'b01;
         end
         S_MEMREAD: adrsrc_s = 1'b1;
         S_MEMWB: begin
            resultsrc_s = 2'b01;
            regwrite_s  = 1'b1;
         end
         S_MEMWRITE: begin
            adrsrc_s   = 1'b1;
            memwrite_s = 1'b1;
         end
         S_EXECR: begin
            alusrca_s = 2'b10;
            aluop     = 2'b10;
         end
         S_EXECI: begin
            alusrca_s = 2'b10;
            alusrcb_s = 2'b01;
            aluop     = 2'b10;
         end
         S_ALUWB: regwrite_s = 1'b1;
         S_JAL: begin
            alusrca_s = 2'b01;
            alusrcb_s = 2'b10;
            pcupdate  = 1'b1;
         end
         S_BEQ: begin
            alusrca_s = 2'b10;
            aluop     = 2'b01;
            branch    = 1'b1;
         end
         default: ;
      endcase
   end

   assign branch_cond = branch_taken(bus.funct3, bus.zero);

   // Write enables are masked while reset is held; selects stay decoded so the datapath sees stable muxes.
   assign bus.PCWrite    = ~reset & (pcupdate | (branch & branch_cond));
   assign bus.IRWrite    = ~reset & irwrite_s;
   assign bus.MemWrite   = ~reset & memwrite_s;
   assign bus.RegWrite   = ~reset & regwrite_s;
   assign bus.AdrSrc     = adrsrc_s;
   assign bus.ResultSrc  = resultsrc_s;
   assign bus.ALUSrcA    = alusrca_s;
   assign bus.ALUSrcB    = alusrcb_s;
   assign bus.ImmSrc     = imm_decode(bus.op);
   assign bus.ALUControl = alu_decode(aluop, bus.funct3, bus.op[5], bus.funct7b5);
   assign bus.State      = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by RV32I encoding.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  7  instruction opcode field (Instr[6:0]) from the instruction register.
REQ-005 funct3  in  3  Instr[14:12].
REQ-006 funct7b5  in  1  Instr[30].
REQ-007 zero  in  1  ALU zero flag, used only in state BEQ.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  write enables and address select.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath mux selects.
REQ-010 ALUControl  out  3  ALU operation code, driven to the ALU control input.
REQ-011 State  out  4  current FSM state encoding, for debug/verification.

Function
REQ-012 FSM states and encodings SHALL be: Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5, ExecuteR=6, ALUWB=7, ExecuteI=8, JAL=9, BEQ=10; values 11-15 SHALL transition to Fetch.
REQ-013 Transitions: Fetch->Decode; Decode->MemAdr (op 0000011 or 0100011), ExecuteR (0110011), ExecuteI (0010011), JAL (1101111), BEQ (1100011), else Fetch; MemAdr->MemRead (0000011) else MemWrite; MemRead->MemWB; ExecuteR, ExecuteI, JAL->ALUWB; MemWB, MemWrite, ALUWB, BEQ->Fetch.
REQ-014 Moore outputs per state (ALUSrcA/ALUSrcB/ResultSrc/ALUOp; unlisted = 0): Fetch 00/10/10/00, IRWrite=1, PCUpdate=1; Decode 01/01/--/00; MemAdr 10/01/--/00; MemRead ResultSrc=00, AdrSrc=1; MemWB ResultSrc=01, RegWrite=1; MemWrite ResultSrc=00, AdrSrc=1, MemWrite=1; ExecuteR 10/00/--/10; ExecuteI 10/01/--/10; ALUWB ResultSrc=00, RegWrite=1; JAL 01/10/00/00, PCUpdate=1; BEQ 10/00/00/01, Branch=1.
REQ-015 PCWrite SHALL equal PCUpdate OR (Branch AND branch condition), combinational in the same cycle; branch condition is zero=1 for funct3=000.
REQ-016 ImmSrc SHALL be decoded combinationally from op: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, others->00.
REQ-017 ALUControl: ALUOp 00->000 (add); 01->001 (sub); 10->by funct3: 000->001 if op[5]&funct7b5 else 000; 010->101 (slt); 110->011 (or); 111->010 (and); other funct3->000.
REQ-018 Exactly one of IRWrite, MemWrite, RegWrite SHALL be high in any cycle, or none.
REQ-019 Latency per instruction (Fetch to return to Fetch): lw 5 cycles, sw 4, R/I-type 4, jal 4, beq 3, unsupported opcode 2.

Reset
REQ-020 reset sampled high at a rising edge SHALL set State to Fetch, regardless of current state, including mid-instruction.
REQ-021 While reset is high, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0 combinationally; mux selects and ALUControl remain as decoded.
REQ-022 First cycle after reset release SHALL be Fetch with IRWrite=1, PCWrite=1.

Configuration
REQ-023 Macro CTRL_BNE_EN: when defined, in BEQ state funct3=001 SHALL use branch condition zero=0 (bne); when undefined, any funct3 other than 000 in BEQ SHALL give branch condition 0 (PCWrite=0).

Verification
REQ-024 reset=1 for 2 cycles from State=7 -> State=0 next edge, all write enables 0 during reset, IRWrite=1 in first cycle after release.
REQ-025 op=0000011 -> State sequence 0,1,2,3,4,0; RegWrite=1 only in State 4, ResultSrc=01 there; ImmSrc=00.
REQ-026 op=0110011, funct3=000, funct7b5=1 -> ExecuteR with ALUControl=001; funct7b5=0 -> 000; op=0010011, funct3=000, funct7b5=1 -> 000.
REQ-027 op=1100011, funct3=000: zero=1 in BEQ -> PCWrite=1, ALUControl=001; zero=0 -> PCWrite=0; next state Fetch in both.
REQ-028 op=1100011, funct3=001, zero=0 -> PCWrite=1 with CTRL_BNE_EN defined, PCWrite=0 without it.
REQ-029 op=1111111 -> State 0,1,0 with no write enable asserted in Decode; op=0100011 -> MemWrite=1 only in State 5, ImmSrc=01.
